washer_panel: RTL and testbench

- Operator-side front end for the washing-machine controller. It drives that controller's coin_in, double_wash and timer_pause inputs and consumes its wash_done output.
- Synchronises and debounces three raw panel contacts (coin sensor, double-wash button, pause button).
- Converts presses into the controller-facing signals: a one-cycle coin pulse plus level-held double/pause selections.
- Shows run/done status and sounds a completion buzzer.

---
 rtl/washer_panel_pkg.sv | 17 +
 rtl/washer_panel_if.sv | 26 ++
 rtl/washer_panel_button_debounce.sv | 51 +++++
 rtl/washer_panel.sv | 119 +++++++++++
 tb/tb_washer_panel.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/washer_panel_pkg.sv
// Shared types and default constants for the washer operator panel.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package washer_panel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DB_WIDTH        = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 10000;
  localparam int DEF_ALERT_WIDTH     = 24;
  localparam int DEF_ALERT_CYCLES    = 2000000;

endpackage

// File: rtl/washer_panel_if.sv
// Panel bundle: raw contacts and wash_done in, controller-facing signals and status out.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are plain levels or single-cycle pulses.
// master = the panel logic, slave = the board side (contacts, controller, LEDs).
interface washer_panel_if;
  logic coin_raw;
  logic double_btn_raw;
  logic pause_btn_raw;
  logic wash_done;
  logic coin_in;
  logic double_wash;
  logic timer_pause;
  logic busy_led;
  logic done_led;
  logic buzzer;

  modport master (
    input  coin_raw, double_btn_raw, pause_btn_raw, wash_done,
    output coin_in, double_wash, timer_pause, busy_led, done_led, buzzer
  );

  modport slave (
    output coin_raw, double_btn_raw, pause_btn_raw, wash_done,
    input  coin_in, double_wash, timer_pause, busy_led, done_led, buzzer
  );
endinterface

// File: rtl/washer_panel_button_debounce.sv
// Synchronise, debounce and edge-detect one raw panel contact.
// Latency: press is visible DEBOUNCE_CYCLES+2 edges after a clean raw edge, consumed on the next edge.
// Backpressure: none; press is a single-cycle pulse on the debounced rising edge.
// Ports: clk, rst, raw (async contact), level (debounced), press (rise pulse).
module button_debounce
  import washer_panel_pkg::*;
#(
  parameter int DB_WIDTH        = DEF_DB_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [DB_WIDTH-1:0] CNT_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                sync1;
  logic                sync2;
  logic                level_q;
  logic [DB_WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      // Counter tracks consecutive samples that disagree with the accepted level;
      // the last of DEBOUNCE_CYCLES disagreeing samples flips the level.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/washer_panel.sv
// Operator panel front end for the wash controller: debounced coin/double/pause, status LEDs, buzzer.
// Latency: clean raw edge to registered output DEBOUNCE_CYCLES+3 cycles; wash_done rise to outputs 1 cycle.
// Backpressure: none; coin_in is a one-cycle pulse, all other outputs are registered levels.
// Ports: clk, rst (async active-high), pif (washer_panel_if.master).
module washer_panel
  import washer_panel_pkg::*;
#(
  parameter int DB_WIDTH        = DEF_DB_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int ALERT_WIDTH     = DEF_ALERT_WIDTH,
  parameter int ALERT_CYCLES    = DEF_ALERT_CYCLES
) (
  input  logic           clk,
  input  logic           rst,
  washer_panel_if.master pif
);

  localparam logic [ALERT_WIDTH-1:0] ALERT_LAST = ALERT_WIDTH'(ALERT_CYCLES - 1);

  logic       coin_press;
  logic       dbl_press;
  logic       pause_press;
  logic [2:0] btn_level_unused;

  button_debounce #(.DB_WIDTH(DB_WIDTH), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_coin (
    .clk(clk), .rst(rst), .raw(pif.coin_raw), .level(btn_level_unused[0]), .press(coin_press)
  );
  button_debounce #(.DB_WIDTH(DB_WIDTH), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_double (
    .clk(clk), .rst(rst), .raw(pif.double_btn_raw), .level(btn_level_unused[1]), .press(dbl_press)
  );
  button_debounce #(.DB_WIDTH(DB_WIDTH), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
    .clk(clk), .rst(rst), .raw(pif.pause_btn_raw), .level(btn_level_unused[2]), .press(pause_press)
  );

  state_t                 state;
  logic                   wash_done_q;
  logic                   done_evt;
  logic [ALERT_WIDTH-1:0] alert_cnt;
  logic                   coin_in_q;
  logic                   double_q;
  logic                   pause_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   buzzer_q;

  // wash_done is already in this clock domain; compare against last cycle's value.
  assign done_evt = pif.wash_done & ~wash_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wash_done_q <= 1'b0;
      alert_cnt   <= '0;
      coin_in_q   <= 1'b0;
      double_q    <= 1'b0;
      pause_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      buzzer_q    <= 1'b0;
    end else begin
      wash_done_q <= pif.wash_done;
      coin_in_q   <= 1'b0;
      case (state)
        IDLE: begin
          // Toggle and coin land on the same edge so the controller samples the new selection with coin_in.
          if (dbl_press) double_q <= ~double_q;
          if (coin_press) begin
            coin_in_q <= 1'b1;
            busy_q    <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          // Completion outranks a coincident pause press.
          if (done_evt) begin
            pause_q   <= 1'b0;
            busy_q    <= 1'b0;
            double_q  <= 1'b0;
            done_q    <= 1'b1;
            buzzer_q  <= 1'b1;
            alert_cnt <= ALERT_LAST;
            state     <= DONE;
          end else if (pause_press) begin
            pause_q <= ~pause_q;
          end
        end
        DONE: begin
          if (buzzer_q) begin
            if (alert_cnt == '0) buzzer_q <= 1'b0;
            else                 alert_cnt <= alert_cnt - 1'b1;
          end
          // double_wash is 0 here, so a double press always selects double.
          if (coin_press) begin
            done_q    <= 1'b0;
            buzzer_q  <= 1'b0;
            coin_in_q <= 1'b1;
            busy_q    <= 1'b1;
            if (dbl_press) double_q <= 1'b1;
            state     <= RUN;
          end else if (dbl_press) begin
            done_q   <= 1'b0;
            buzzer_q <= 1'b0;
            double_q <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pif.coin_in     = coin_in_q;
  assign pif.double_wash = double_q;
  assign pif.timer_pause = pause_q;
  assign pif.busy_led    = busy_q;
  assign pif.done_led    = done_q;
  assign pif.buzzer      = buzzer_q;

endmodule

// File: tb/tb_washer_panel.sv
// Directed bench for washer_panel with short debounce and alert times.
// Latency: n/a.
// Backpressure: n/a.
module tb_washer_panel;

  localparam int DB  = 4;
  localparam int AL  = 8;
  localparam int LAT = DB + 3;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  washer_panel_if pif();

  washer_panel #(
    .DB_WIDTH(16), .DEBOUNCE_CYCLES(DB), .ALERT_WIDTH(24), .ALERT_CYCLES(AL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pif(pif)
  );

  always #5 clk = ~clk;

  // {coin_in, double_wash, timer_pause, busy_led, done_led, buzzer}
  function automatic logic [5:0] outs();
    return {pif.coin_in, pif.double_wash, pif.timer_pause, pif.busy_led, pif.done_led, pif.buzzer};
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Raise one contact and stop just after the edge where its press takes effect.
  task automatic press(input int which);
    @(negedge clk);
    case (which)
      0:       pif.coin_raw       = 1'b1;
      1:       pif.double_btn_raw = 1'b1;
      default: pif.pause_btn_raw  = 1'b1;
    endcase
    repeat (LAT) @(posedge clk);
    #1;
  endtask

  task automatic release_all();
    @(negedge clk);
    pif.coin_raw       = 1'b0;
    pif.double_btn_raw = 1'b0;
    pif.pause_btn_raw  = 1'b0;
    repeat (LAT + 3) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int pulses;
    int buzz;

    rst                = 1'b1;
    pif.coin_raw       = 1'b0;
    pif.double_btn_raw = 1'b0;
    pif.pause_btn_raw  = 1'b0;
    pif.wash_done      = 1'b0;
    @(posedge clk);
    #1;
    check("reset_outputs", outs(), 6'b000000);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Pause in IDLE is ignored.
    press(2);
    check("idle_pause_ignored", {5'b0, pif.timer_pause}, 6'd0);
    release_all();

    // Double select toggles 1, 0, 1.
    press(1);
    check("double_1", {5'b0, pif.double_wash}, 6'd1);
    release_all();
    press(1);
    check("double_2", {5'b0, pif.double_wash}, 6'd0);
    release_all();
    press(1);
    check("double_3", {5'b0, pif.double_wash}, 6'd1);
    release_all();

    // Bounce rejection on coin, then a clean rise held high.
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      pif.coin_raw = ~pif.coin_raw;
      repeat (2) @(negedge clk);
    end
    pif.coin_raw = 1'b1;
    pulses = 0;
    for (int k = 1; k <= LAT + 10; k++) begin
      @(posedge clk);
      #1;
      if (pif.coin_in) pulses++;
      if (k == LAT - 1) check("coin_before_lat", outs(), 6'b010000);
      if (k == LAT)     check("coin_at_lat", outs(), 6'b110100);
      if (k == LAT + 1) check("coin_one_wide", {5'b0, pif.coin_in}, 6'd0);
    end
    check("coin_single_pulse", 6'(pulses), 6'd1);
    release_all();

    // RUN: double and coin presses ignored.
    press(1);
    check("run_double_frozen", outs(), 6'b010100);
    release_all();
    press(0);
    check("run_coin_ignored", outs(), 6'b010100);
    release_all();

    // RUN: pause toggles.
    press(2);
    check("pause_on", {5'b0, pif.timer_pause}, 6'd1);
    release_all();
    press(2);
    check("pause_off", {5'b0, pif.timer_pause}, 6'd0);
    release_all();

    // Completion.
    @(negedge clk);
    pif.wash_done = 1'b1;
    @(posedge clk);
    #1;
    check("done_entry", outs(), 6'b000011);
    buzz = 1;
    repeat (AL + 4) begin
      @(posedge clk);
      #1;
      if (pif.buzzer) buzz++;
    end
    check("buzzer_cycles", 6'(buzz), 6'(AL));
    check("done_hold", outs(), 6'b000010);
    @(negedge clk);
    pif.wash_done = 1'b0;

    // Coin in DONE restarts.
    press(0);
    check("done_coin", outs(), 6'b100100);
    release_all();
    press(2);
    check("pause_before_sim", {5'b0, pif.timer_pause}, 6'd1);
    release_all();

    // Pause press and done event on the same edge: done wins.
    @(negedge clk);
    pif.pause_btn_raw = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    pif.wash_done = 1'b1;
    @(posedge clk);
    #1;
    check("sim_pause_done", outs(), 6'b000011);
    @(negedge clk);
    pif.wash_done = 1'b0;
    release_all();

    // Double in DONE returns to IDLE with double selected.
    press(1);
    check("done_double", outs(), 6'b010000);
    release_all();
    press(0);
    check("idle_coin_double", outs(), 6'b110100);
    release_all();
    press(2);
    check("pre_reset_state", outs(), 6'b011100);

    // Asynchronous reset mid-run, coin held through release.
    @(negedge clk);
    pif.pause_btn_raw = 1'b0;
    pif.coin_raw      = 1'b1;
    rst               = 1'b1;
    #1;
    check("async_reset", outs(), 6'b000000);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset_coin_k%0d", k), {5'b0, pif.coin_in}, (k == LAT) ? 6'd1 : 6'd0);
    end
    release_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
